// File: rtl/pipe_if_queue_if.sv
// Handshake bundle between the fetch stage, the fetch queue and decode.
// master: the side producing fetches and control (IF/ID).
// slave:  the queue itself.
interface pipe_if_queue_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic [PC_W-1:0]    in_pc;
  logic [PC_W-1:0]    in_npc;
  logic [INSTR_W-1:0] in_instruction;
  logic               out_ready;
  logic               in_stall;
  logic               in_branch;
  logic               out_valid;
  logic [PC_W-1:0]    out_pc;
  logic [PC_W-1:0]    out_npc;
  logic [INSTR_W-1:0] out_instruction;
  logic [CW-1:0]      out_count;
  logic               out_full;
  logic               out_empty;
  logic [CNT_W-1:0]   out_discard_count;

  modport master (
    output in_valid, in_pc, in_npc, in_instruction, in_stall, in_branch,
    input  out_ready, out_valid, out_pc, out_npc, out_instruction,
           out_count, out_full, out_empty, out_discard_count
  );

  modport slave (
    input  in_valid, in_pc, in_npc, in_instruction, in_stall, in_branch,
    output out_ready, out_valid, out_pc, out_npc, out_instruction,
           out_count, out_full, out_empty, out_discard_count
  );
endinterface

// File: rtl/pipe_if_queue.sv
// Instruction fetch queue between IF and ID: first-word-fall-through FIFO
// of {pc, npc, instruction}. A branch redirect empties it and adds the
// dropped occupancy to a saturating discard counter.
module pipe_if_queue #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               in_clk,
  input  logic               in_rst,
  pipe_if_queue_if.slave     q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Sum width large enough that disc + count can never wrap before the
  // saturation compare.
  localparam int SW = ((CNT_W > CW) ? CNT_W : CW) + 1;
  localparam logic [SW-1:0] DISC_MAX = SW'({CNT_W{1'b1}});

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    npc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic [SW-1:0]    disc_sum;

  logic full, empty, push, pop;
  entry_t head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // No pop-to-push bypass when full: ready depends on registered state only.
  assign push  = q.in_valid && !full && !q.in_branch;
  assign pop   = !empty && !q.in_stall && !q.in_branch;
  assign head  = mem_q[rd_ptr_q];

  assign q.out_ready         = !full;
  assign q.out_valid         = !empty;
  assign q.out_full          = full;
  assign q.out_empty         = empty;
  assign q.out_count         = count_q;
  assign q.out_discard_count = disc_q;
  // Storage is not reset, so head fields are forced to zero (a NOP bubble)
  // whenever nothing valid is queued.
  assign q.out_pc            = empty ? '0 : head.pc;
  assign q.out_npc           = empty ? '0 : head.npc;
  assign q.out_instruction   = empty ? '0 : head.instr;

  assign disc_sum = SW'(disc_q) + SW'(count_q);

  // Next-state for pointers, occupancy and discard counter; flush wins.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    disc_d   = disc_q;
    if (q.in_branch) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      disc_d   = (disc_sum > DISC_MAX) ? {CNT_W{1'b1}} : disc_sum[CNT_W-1:0];
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state; async reset drops every entry immediately.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      disc_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      disc_q   <= disc_d;
    end
  end

  // Entry storage, written only on an accepted push; intentionally unreset.
  always_ff @(posedge in_clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: q.in_pc, npc: q.in_npc, instr: q.in_instruction};
  end
endmodule
